// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: word loads/stores, sub-word loads with extension, and
// sub-word stores via read-modify-write. Build option MEM_MISALIGN_CHECK_EN enables error responses.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_read_e,
    output logic              mem_write_e,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStore,
        StRmwRd,
        StRmwWr
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word_q, word_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic [ADDR_W+1:0] req_addr_n;
    logic [1:0]        req_size_n;
    logic              req_misaligned;
    logic              accept;
    logic [4:0]        lane_shift;
    logic [31:0]       load_shifted;
    logic [31:0]       load_ext;
    logic [31:0]       lane_mask;
    logic [31:0]       merged;
    logic              write_raw;

    always_comb begin
        req_addr_n = req_addr;
        req_size_n = req_size;
`ifdef MEM_MISALIGN_CHECK_EN
        req_misaligned = (req_size == 2'b11) ||
                         (req_size == 2'b01 && req_addr[0]) ||
                         (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
        // Without checking, force natural alignment; reserved size behaves as a word access.
        req_misaligned = 1'b0;
        if (req_size == 2'b11) begin
            req_size_n = 2'b10;
        end
        if (req_size_n == 2'b01) begin
            req_addr_n[0] = 1'b0;
        end
        if (req_size_n == 2'b10) begin
            req_addr_n[1:0] = 2'b00;
        end
`endif
    end

    assign accept     = req_valid && (state_q == StIdle);
    assign lane_shift = {addr_q[1:0], 3'b000};

    always_comb begin
        load_shifted = mem_read_data >> lane_shift;
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'h0, load_shifted[7:0]}
                                           : {{24{load_shifted[7]}}, load_shifted[7:0]};
            2'b01:   load_ext = unsigned_q ? {16'h0, load_shifted[15:0]}
                                           : {{16{load_shifted[15]}}, load_shifted[15:0]};
            default: load_ext = mem_read_data;
        endcase
    end

    always_comb begin
        lane_mask = (size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff;
        merged    = (word_q & ~(lane_mask << lane_shift)) | ((wdata_q & lane_mask) << lane_shift);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && !req_misaligned) begin
                    if (!req_we) begin
                        state_d = StLoad;
                    end else if (req_size_n == 2'b10) begin
                        state_d = StStore;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRmwRd: state_d = StRmwWr;
            StLoad, StStore, StRmwWr: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == StIdle);
        stall          = (state_q != StIdle);
        mem_address    = '0;
        mem_write_data = '0;
        mem_read_e     = 1'b0;
        write_raw      = 1'b0;
        unique case (state_q)
            StLoad, StRmwRd: begin
                mem_read_e  = 1'b1;
                mem_address = addr_q[ADDR_W+1:2];
            end
            StStore: begin
                write_raw      = 1'b1;
                mem_address    = addr_q[ADDR_W+1:2];
                mem_write_data = wdata_q;
            end
            StRmwWr: begin
                write_raw      = 1'b1;
                mem_address    = addr_q[ADDR_W+1:2];
                mem_write_data = merged;
            end
            default: ;
        endcase
        mem_write_e = write_raw & ~reset;
        resp_valid  = resp_valid_q;
        resp_err    = resp_err_q;
        resp_rdata  = resp_rdata_q;
    end

    always_comb begin
        addr_d       = accept ? req_addr_n : addr_q;
        size_d       = accept ? req_size_n : size_q;
        unsigned_d   = accept ? req_unsigned : unsigned_q;
        wdata_d      = accept ? req_wdata : wdata_q;
        word_d       = (state_q == StRmwRd) ? mem_read_data : word_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        if (accept && req_misaligned) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
        end
        unique case (state_q)
            StLoad: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_ext;
            end
            StStore, StRmwWr: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            word_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            addr_q       <= addr_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-lane reference model with per-cycle compare, directed
// literal checks and randomized traffic with occasional resets.
module tb_mem_access_unit;

    localparam int unsigned AW     = 7;
    localparam int unsigned NWORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          stall;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          mem_read_e;
    logic          mem_write_e;
    logic [31:0]   mem_read_data;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .stall          (stall),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_e     (mem_read_e),
        .mem_write_e    (mem_write_e),
        .mem_read_data  (mem_read_data)
    );

    // Memory with write-data bypass while write_e is high.
    logic [31:0] phys_mem [NWORDS] = '{default: 32'h0};
    assign mem_read_data = mem_write_e ? mem_write_data : phys_mem[mem_address];
    always @(posedge clk) begin
        if (mem_write_e) phys_mem[mem_address] <= mem_write_data;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: one outstanding operation at a time.
    logic [31:0]   shadow [NWORDS] = '{default: 32'h0};
    int            cyc = 0;
    int            busy_until = -1;
    bit            p_active = 0;
    int            p_kind = 0;  // 0 error, 1 load, 2 word store, 3 sub-word store
    int            p_start = 0;
    int            p_resp_cyc = 0;
    logic [AW-1:0] p_widx = '0;
    logic [31:0]   p_rdata = '0;
    logic [31:0]   p_new = '0;
    bit            p_err = 0;

    task automatic model_accept();
        logic [1:0]    sz;
        logic [AW+1:0] a;
        logic [31:0]   w;
        logic [31:0]   v;
        int            nb;
        int            base;
        int            lat;
        bit            mis;
        sz  = req_size;
        a   = req_addr;
        mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`ifndef MEM_MISALIGN_CHECK_EN
        if (sz == 2'd3) sz = 2'd2;
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'd0;
        mis = 0;
`endif
        nb       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base     = int'(a[1:0]);
        p_widx   = a[AW+1:2];
        w        = shadow[p_widx];
        p_active = 1;
        p_start  = cyc;
        p_err    = 0;
        p_rdata  = 32'h0;
        p_new    = w;
        if (mis) begin
            p_kind = 0; lat = 1; p_err = 1;
        end else if (!req_we) begin
            p_kind = 1; lat = 2;
            v = 32'h0;
            for (int k = 0; k < nb; k++) v = v | (32'(w[8*(base+k) +: 8]) << (8*k));
            if (!req_unsigned && nb < 4 && v >= (32'd1 << (8*nb - 1))) v = v - (32'd1 << (8*nb));
            p_rdata = v;
        end else begin
            p_kind = (nb == 4) ? 2 : 3;
            lat    = (nb == 4) ? 2 : 3;
            for (int k = 0; k < nb; k++) p_new[8*(base+k) +: 8] = req_wdata[8*k +: 8];
        end
        p_resp_cyc = cyc + lat - 1;
        busy_until = cyc + lat - 2;
    endtask

    initial begin : model
        int cyc_old;
        forever begin
            @(posedge clk);
            cyc_old = cyc;
            cyc = cyc + 1;
            if (reset) begin
                p_active = 0;
                busy_until = cyc - 1;
            end else begin
                if (p_active && cyc == p_resp_cyc && p_kind >= 2) shadow[p_widx] = p_new;
                if (p_active && cyc > p_resp_cyc) p_active = 0;
                if (req_valid && cyc_old > busy_until) model_accept();
            end
        end
    end

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t rq[$];

    initial begin : compare
        bit    busy;
        bit    exp_v;
        int    phase;
        resp_t rec;
        forever begin
            @(negedge clk);
            #1;
            if (cyc >= 1) begin
                busy  = (cyc <= busy_until);
                exp_v = p_active && (cyc == p_resp_cyc);
                chk("stall", 64'(stall), 64'(busy));
                chk("req_ready", 64'(req_ready), 64'(!busy));
                chk("resp_valid", 64'(resp_valid), 64'(exp_v));
                if (exp_v && resp_valid) begin
                    chk("resp_err", 64'(resp_err), 64'(p_err));
                    chk("resp_rdata", 64'(resp_rdata), 64'(p_rdata));
                end
                if (resp_valid) begin
                    rec.cyc = cyc; rec.rdata = resp_rdata; rec.err = resp_err;
                    rq.push_back(rec);
                end
                if (!busy) begin
                    chk("mem_idle", 64'({mem_address, mem_write_data, mem_read_e, mem_write_e}),
                        64'h0);
                end else if (p_active) begin
                    phase = cyc - p_start;
                    if ((p_kind == 1 || p_kind == 3) && phase == 0) begin
                        chk("rd_access", 64'({mem_read_e, mem_write_e, mem_address}),
                            64'({1'b1, 1'b0, p_widx}));
                    end else if ((p_kind == 2 && phase == 0) || (p_kind == 3 && phase == 1)) begin
                        chk("wr_access", 64'({mem_write_e, mem_address}), 64'({!reset, p_widx}));
                        chk("wr_data", 64'(mem_write_data), 64'(p_new));
                    end
                end
            end
        end
    end

    task automatic send(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [AW+1:0] a, input logic [31:0] wd, output int acc);
        int waited;
        waited = 0;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            chk("accept_wait", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            req_valid = 1'b0;
        end
    endtask

    task automatic get_resp(output resp_t r);
        int waited;
        waited = 0;
        while (rq.size() == 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (rq.size() == 0) begin
            chk("resp_wait", 64'(rq.size()), 64'd1);
            r.cyc = -100; r.rdata = 32'hx; r.err = 1'bx;
        end else begin
            r = rq.pop_front();
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        resp_t r1, r2;
        int    a1, a2;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_resp", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);

        // Word store then word load.
        rq.delete();
        send(1, 2'd2, 0, 9'h010, 32'hDEADBEEF, a1); get_resp(r1);
        send(0, 2'd2, 0, 9'h010, 32'h0, a2);        get_resp(r2);
        chk("t1_st_err", 64'(r1.err), 64'd0);
        chk("t1_mem", 64'(phys_mem[4]), 64'hDEADBEEF);
        chk("t1_ld_data", 64'(r2.rdata), 64'hDEADBEEF);
        chk("t1_ld_lat", 64'(r2.cyc - a2 + 1), 64'd2);

        // Byte/half loads with extension.
        send(1, 2'd2, 0, 9'h010, 32'h80FF7F01, a1); get_resp(r1);
        send(0, 2'd0, 0, 9'h013, 32'h0, a2); get_resp(r2);
        chk("t2_lb_signed", 64'(r2.rdata), 64'hFFFFFF80);
        send(0, 2'd0, 1, 9'h013, 32'h0, a2); get_resp(r2);
        chk("t2_lb_unsigned", 64'(r2.rdata), 64'h00000080);
        send(0, 2'd1, 0, 9'h012, 32'h0, a2); get_resp(r2);
        chk("t2_lh_signed", 64'(r2.rdata), 64'hFFFF80FF);
        send(0, 2'd0, 0, 9'h011, 32'h0, a2); get_resp(r2);
        chk("t2_lb_pos", 64'(r2.rdata), 64'h0000007F);

        // Byte store via read-modify-write.
        send(1, 2'd2, 0, 9'h010, 32'h11223344, a1); get_resp(r1);
        send(1, 2'd0, 0, 9'h011, 32'hFFFFFFAA, a2); get_resp(r2);
        chk("t3_mem", 64'(phys_mem[4]), 64'h1122AA44);
        chk("t3_lat", 64'(r2.cyc - a2 + 1), 64'd3);
        chk("t3_err", 64'(r2.err), 64'd0);

        // Misaligned half load.
        send(0, 2'd1, 0, 9'h003 + 9'h010, 32'h0, a2); get_resp(r2);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("t4_err", 64'({r2.err, r2.rdata}), 64'({1'b1, 32'h0}));
        chk("t4_lat", 64'(r2.cyc - a2 + 1), 64'd1);
`else
        chk("t4_data", 64'({r2.err, r2.rdata}), 64'({1'b0, 32'h00001122}));
        chk("t4_lat", 64'(r2.cyc - a2 + 1), 64'd2);
`endif

        // Reset during the write phase of a half store aborts it.
        send(1, 2'd2, 0, 9'h020, 32'h55667788, a1); get_resp(r1);
        rq.delete();
        send(1, 2'd1, 0, 9'h022, 32'h0000BEEF, a2);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_mem", 64'(phys_mem[8]), 64'h55667788);
        chk("t5_no_resp", 64'(rq.size()), 64'd0);
        chk("t5_ready", 64'(req_ready), 64'd1);

        // Back-to-back: load accepted in the store's response cycle.
        rq.delete();
        send(1, 2'd2, 0, 9'h030, 32'hCAFEF00D, a1);
        send(0, 2'd2, 0, 9'h030, 32'h0, a2);
        get_resp(r1); get_resp(r2);
        chk("t6_st_resp", 64'({r1.err, r1.rdata}), 64'd0);
        chk("t6_ld_data", 64'(r2.rdata), 64'hCAFEF00D);
        chk("t6_no_gap", 64'(a2), 64'(r1.cyc + 1));

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 9'($urandom_range(0, 127)), $urandom, a1);
            if ($urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);
        for (int w = 0; w < 32; w++) begin
            chk($sformatf("final_mem[%0d]", w), 64'(phys_mem[w]), 64'(shadow[w]));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
